// File: rtl/ahb_pkg.sv
// AHB protocol encodings and the DMA master state set shared by the
// ahb_rsa2048 copy engine and its bench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD_A,
        ST_RD_D,
        ST_WR_A,
        ST_WR_D,
        ST_FIN
    } dma_state_e;

endpackage

// File: rtl/ahb_rsa2048_dma_master.sv
// Word-by-word AHB copy engine: one SINGLE read then one SINGLE write per
// word, keeping the bus requested for the whole block.
module ahb_rsa2048_dma_master
    import ahb_pkg::*;
#(
    parameter int         LEN_W     = 16,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] num_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mHBUSREQ,
    input  logic             mHGRANT,
    output logic [31:0]      mHADDR,
    output logic [1:0]       mHTRANS,
    output logic             mHWRITE,
    output logic [2:0]       mHSIZE,
    output logic [2:0]       mHBURST,
    output logic [3:0]       mHPROT,
    output logic             mHLOCK,
    output logic [31:0]      mHWDATA,
    input  logic [31:0]      mHRDATA,
    input  logic [1:0]       mHRESP,
    input  logic             mHREADY
);

    dma_state_e       state, state_nxt;
    logic [31:0]      src_ptr, dst_ptr, data_reg;
    logic [LEN_W-1:0] remaining;
    logic             err_q;
    logic             last_word, resp_ok;

    assign last_word = (remaining == LEN_W'(1));
    assign resp_ok   = (mHRESP == HRESP_OKAY);

    assign mHSIZE  = HSIZE_WORD;
    assign mHBURST = HBURST_SINGLE;
    assign mHPROT  = HPROT_VAL;
    assign mHLOCK  = 1'b0;
    assign mHWDATA = data_reg;
    assign error   = err_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mHBUSREQ  = 1'b0;
        mHTRANS   = HTRANS_IDLE;
        mHWRITE   = 1'b0;
        mHADDR    = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = (num_words == '0) ? ST_FIN : ST_REQ;
            end
            ST_REQ: begin
                busy     = 1'b1;
                mHBUSREQ = 1'b1;
                mHADDR   = src_ptr;
                if (mHGRANT && mHREADY) state_nxt = ST_RD_A;
            end
            ST_RD_A: begin
                busy     = 1'b1;
                mHBUSREQ = 1'b1;
                mHADDR   = src_ptr;
                // Losing the grant before the read is issued: re-arbitrate,
                // pointers untouched.
                if (!mHGRANT) begin
                    state_nxt = ST_REQ;
                end else begin
                    mHTRANS = HTRANS_NONSEQ;
                    if (mHREADY) state_nxt = ST_RD_D;
                end
            end
            ST_RD_D: begin
                busy     = 1'b1;
                mHBUSREQ = 1'b1;
                mHADDR   = src_ptr;
                if (mHREADY) state_nxt = resp_ok ? ST_WR_A : ST_IDLE;
            end
            ST_WR_A: begin
                busy     = 1'b1;
                mHBUSREQ = 1'b1;
                mHWRITE  = 1'b1;
                mHADDR   = dst_ptr;
                if (mHGRANT) begin
                    mHTRANS = HTRANS_NONSEQ;
                    if (mHREADY) state_nxt = ST_WR_D;
                end
            end
            ST_WR_D: begin
                busy     = 1'b1;
                mHBUSREQ = !last_word;
                mHWRITE  = 1'b1;
                mHADDR   = dst_ptr;
                if (mHREADY) begin
                    if (!resp_ok)       state_nxt = ST_IDLE;
                    else if (last_word) state_nxt = ST_FIN;
                    else                state_nxt = ST_RD_A;
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data_reg  <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr & ~32'h3;
                        dst_ptr   <= dst_addr & ~32'h3;
                        remaining <= num_words;
                    end
                end
                ST_RD_D: begin
                    if (mHREADY) begin
                        if (resp_ok) data_reg <= mHRDATA;
                        else         err_q    <= 1'b1;
                    end
                end
                ST_WR_D: begin
                    if (mHREADY) begin
                        if (resp_ok) begin
                            src_ptr   <= src_ptr + 32'd4;
                            dst_ptr   <= dst_ptr + 32'd4;
                            remaining <= remaining - LEN_W'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
